// File: rtl/crono_countdown.sv
// Chronometer countdown: captures a clamped BCD HH:MM:SS preset, counts it down per 1 Hz tick, raises an alarm at zero.
// Optional build macro CRONO_BLINK_EN makes the alarm toggle on each tick while in DONE.
module crono_countdown #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       alarm_clr,
  input  logic [7:0] HCcr_in,
  input  logic [7:0] MCcr_in,
  input  logic [7:0] SCcr_in,
  output logic [7:0] HCout,
  output logic [7:0] MCout,
  output logic [7:0] SCout,
  output logic       running,
  output logic       done_pulse,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAUSED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_INIT = 8'(ALARM_SECS);

  state_t      state_r;
  logic [7:0]  alarm_cnt_r;
  logic [23:0] preset_s;
  logic [23:0] count_s;
  logic [23:0] dec_s;

  // Minutes/seconds digit clamp: tens to 5, units to 9.
  function automatic logic [7:0] clamp_ms(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  // Hours clamp: tens to 2, units to 9, then anything above 23 to 23.
  function automatic logic [7:0] clamp_hours(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > 4'd2) ? 4'd2 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    u = ((t == 4'd2) && (u > 4'd3)) ? 4'd3 : u;
    return {t, u};
  endfunction

  // One BCD digit with borrow: returns {borrow_out, digit_out}.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] top,
                                           input logic b_in);
    if (!b_in) begin
      return {1'b0, d};
    end else if (d == 4'd0) begin
      return {1'b1, top};
    end else begin
      return {1'b0, d - 4'd1};
    end
  endfunction

  // Whole-time decrement; 00:00:00 wraps to 23:59:59 so no non-BCD value can appear.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [4:0] r0, r1, r2, r3, r4, r5;
    if (v == 24'h000000) begin
      return 24'h235959;
    end else begin
      r0 = dec_digit(v[3:0],   4'd9, 1'b1);
      r1 = dec_digit(v[7:4],   4'd5, r0[4]);
      r2 = dec_digit(v[11:8],  4'd9, r1[4]);
      r3 = dec_digit(v[15:12], 4'd5, r2[4]);
      r4 = dec_digit(v[19:16], 4'd9, r3[4]);
      r5 = dec_digit(v[23:20], 4'd2, r4[4]);
      return {r5[3:0], r4[3:0], r3[3:0], r2[3:0], r1[3:0], r0[3:0]};
    end
  endfunction

  assign preset_s = {clamp_hours(HCcr_in), clamp_ms(MCcr_in), clamp_ms(SCcr_in)};
  assign count_s  = {HCout, MCout, SCout};
  assign dec_s    = bcd_dec(count_s);
  assign running  = (state_r == RUN);

  // Control FSM with registered time, alarm and expiry outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      HCout       <= 8'h00;
      MCout       <= 8'h00;
      SCout       <= 8'h00;
      done_pulse  <= 1'b0;
      alarm       <= 1'b0;
      alarm_cnt_r <= 8'd0;
    end else begin
      done_pulse <= 1'b0;
      if (load && (state_r != RUN)) begin
        {HCout, MCout, SCout} <= preset_s;
        state_r     <= (preset_s != 24'h000000) ? PAUSED : IDLE;
        alarm       <= 1'b0;
        alarm_cnt_r <= 8'd0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          PAUSED: begin
            state_r <= start ? RUN : PAUSED;
          end
          RUN: begin
            if (stop) begin
              state_r <= PAUSED;
            end else if (tick_1hz) begin
              {HCout, MCout, SCout} <= dec_s;
              if (dec_s == 24'h000000) begin
                state_r     <= DONE;
                done_pulse  <= 1'b1;
                alarm       <= 1'b1;
                alarm_cnt_r <= ALARM_INIT;
              end else begin
                state_r <= RUN;
              end
            end else begin
              state_r <= RUN;
            end
          end
          DONE: begin
            if (alarm_clr) begin
              state_r     <= IDLE;
              alarm       <= 1'b0;
              alarm_cnt_r <= 8'd0;
            end else if (tick_1hz) begin
              if (alarm_cnt_r <= 8'd1) begin
                state_r     <= IDLE;
                alarm       <= 1'b0;
                alarm_cnt_r <= 8'd0;
              end else begin
                alarm_cnt_r <= alarm_cnt_r - 8'd1;
`ifdef CRONO_BLINK_EN
                alarm <= ~alarm;
`else
                alarm <= 1'b1;
`endif
              end
            end else begin
              state_r <= DONE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crono_countdown.sv
// Self-checking bench for crono_countdown: stepped stimulus with a scoreboard queue of expected outputs.
module tb_crono_countdown;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, alarm_clr = 1'b0;
  logic [7:0] HCcr_in = 8'h00, MCcr_in = 8'h00, SCcr_in = 8'h00;
  logic [7:0] HCout, MCout, SCout;
  logic       running, done_pulse, alarm;

  int n_cmp  = 0;
  int n_fail = 0;

  // ctl = {load, start, stop, alarm_clr, tick}; flags = {running, done_pulse, alarm}
  typedef struct packed {
    logic [4:0]  ctl;
    logic [23:0] pre;
    logic [23:0] t;
    logic [2:0]  flags;
  } step_t;

  localparam logic [4:0] NO = 5'b00000, LD = 5'b10000, ST = 5'b01000, SP = 5'b00100,
                         CL = 5'b00010, TK = 5'b00001;

  logic [26:0] sb[$];

  crono_countdown #(.ALARM_SECS(10)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load), .start(start), .stop(stop),
    .alarm_clr(alarm_clr), .HCcr_in(HCcr_in), .MCcr_in(MCcr_in), .SCcr_in(SCcr_in),
    .HCout(HCout), .MCout(MCout), .SCout(SCout), .running(running),
    .done_pulse(done_pulse), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [4:0] ctl, input logic [23:0] pre,
                               input logic [23:0] t, input logic [2:0] flags);
    step_t s;
    s.ctl = ctl; s.pre = pre; s.t = t; s.flags = flags;
    return s;
  endfunction

  // Drives one step for a single clock and queues what the DUT must show afterwards.
  task automatic drive(input step_t s);
    {load, start, stop, alarm_clr, tick_1hz} = s.ctl;
    {HCcr_in, MCcr_in, SCcr_in} = s.pre;
    sb.push_back({s.t, s.flags});
    @(posedge clk);
    #1;
    {load, start, stop, alarm_clr, tick_1hz} = 5'b00000;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    reset = 1'b0;
    sb.push_back(27'd0);
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", {HCout, MCout, SCout, running, done_pulse, alarm}, e);
    end
    reset = 1'b1;
  endtask

  task automatic test_decrement();
    step_t q[$];
    logic [26:0] e;
    q = '{mk(LD, 24'h000100, 24'h000100, 3'b000), mk(ST, 24'h0, 24'h000100, 3'b100),
          mk(TK, 24'h0, 24'h000059, 3'b100), mk(SP, 24'h0, 24'h000059, 3'b000),
          mk(LD, 24'h100000, 24'h100000, 3'b000), mk(ST, 24'h0, 24'h100000, 3'b100),
          mk(TK, 24'h0, 24'h095959, 3'b100), mk(SP, 24'h0, 24'h095959, 3'b000),
          mk(LD, 24'h200000, 24'h200000, 3'b000), mk(ST, 24'h0, 24'h200000, 3'b100),
          mk(TK, 24'h0, 24'h195959, 3'b100), mk(SP, 24'h0, 24'h195959, 3'b000)};
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL decrement step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
  endtask

  task automatic test_expiry();
    step_t q[$];
    logic [26:0] e;
    logic al;
    q = '{mk(LD, 24'h000002, 24'h000002, 3'b000), mk(ST, 24'h0, 24'h000002, 3'b100),
          mk(TK, 24'h0, 24'h000001, 3'b100), mk(TK, 24'h0, 24'h000000, 3'b011),
          mk(NO, 24'h0, 24'h000000, 3'b001)};
    for (int k = 1; k <= 10; k++) begin
`ifdef CRONO_BLINK_EN
      al = (k < 10) && (k % 2 == 0);
`else
      al = (k < 10);
`endif
      q.push_back(mk(TK, 24'h0, 24'h000000, {2'b00, al}));
    end
    q.push_back(mk(ST, 24'h0, 24'h000000, 3'b000));
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL expiry step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
  endtask

  task automatic test_stop_tick();
    step_t q[$];
    logic [26:0] e;
    q = '{mk(LD, 24'h000031, 24'h000031, 3'b000), mk(ST, 24'h0, 24'h000031, 3'b100),
          mk(TK, 24'h0, 24'h000030, 3'b100), mk(SP | TK, 24'h0, 24'h000030, 3'b000),
          mk(ST | TK, 24'h0, 24'h000030, 3'b100), mk(TK, 24'h0, 24'h000029, 3'b100),
          mk(SP, 24'h0, 24'h000029, 3'b000), mk(TK, 24'h0, 24'h000029, 3'b000)};
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL stop_tick step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
  endtask

  task automatic test_clamp();
    step_t q[$];
    logic [26:0] e;
    q = '{mk(LD, 24'h397AFF, 24'h235959, 3'b000), mk(ST, 24'h0, 24'h235959, 3'b100),
          mk(LD, 24'h000005, 24'h235959, 3'b100), mk(TK, 24'h0, 24'h235958, 3'b100),
          mk(SP, 24'h0, 24'h235958, 3'b000), mk(LD, 24'h1F4B60, 24'h194950, 3'b000),
          mk(LD, 24'h2A6C59, 24'h235959, 3'b000), mk(LD, 24'h000000, 24'h000000, 3'b000),
          mk(ST, 24'h0, 24'h000000, 3'b000), mk(TK, 24'h0, 24'h000000, 3'b000)};
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL clamp step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t q[$];
    logic [26:0] e;
    q = '{mk(LD, 24'h000500, 24'h000500, 3'b000), mk(ST, 24'h0, 24'h000500, 3'b100),
          mk(TK, 24'h0, 24'h000459, 3'b100)};
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL async_reset step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
    #2;
    reset = 1'b0;
    sb.push_back(27'd0);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
      n_fail++;
      $display("FAIL async_reset immediate: got %h expected %h",
               {HCout, MCout, SCout, running, done_pulse, alarm}, e);
    end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alarm_clr();
    step_t q[$];
    logic [26:0] e;
    q = '{mk(LD, 24'h000001, 24'h000001, 3'b000), mk(ST, 24'h0, 24'h000001, 3'b100),
          mk(TK, 24'h0, 24'h000000, 3'b011), mk(CL, 24'h0, 24'h000000, 3'b000),
          mk(ST, 24'h0, 24'h000000, 3'b000),
          mk(LD, 24'h000001, 24'h000001, 3'b000), mk(ST, 24'h0, 24'h000001, 3'b100),
          mk(TK, 24'h0, 24'h000000, 3'b011), mk(ST | SP, 24'h0, 24'h000000, 3'b001),
          mk(LD, 24'h000003, 24'h000003, 3'b000), mk(ST, 24'h0, 24'h000003, 3'b100),
          mk(SP, 24'h0, 24'h000003, 3'b000)};
    foreach (q[i]) begin
      drive(q[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({HCout, MCout, SCout, running, done_pulse, alarm} !== e) begin
        n_fail++;
        $display("FAIL alarm_clr step %0d: got %h expected %h", i,
                 {HCout, MCout, SCout, running, done_pulse, alarm}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decrement();
    test_expiry();
    test_stop_tick();
    test_clamp();
    test_async_reset();
    test_alarm_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/crono_countdown.md
Name: crono_countdown

Overview:
Countdown engine for the chronometer. It sits directly downstream of the chronometer setter that produces the BCD preset HH:MM:SS on HCcr/MCcr/SCcr. It captures the preset on a load pulse and counts it down once per 1 Hz tick. On reaching 00:00:00 it raises an alarm that the display and buzzer stages consume.

Parameters:
ALARM_SECS, 10, number of tick_1hz pulses the alarm stays active after expiry (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low
tick_1hz  input  1  one-clk-wide pulse, once per second
load  input  1  one-clk pulse; capture HCcr_in/MCcr_in/SCcr_in
start  input  1  one-clk pulse; begin or resume counting
stop  input  1  one-clk pulse; pause counting
alarm_clr  input  1  one-clk pulse; end alarm early
HCcr_in  input  8  preset hours, BCD {tens,units}
MCcr_in  input  8  preset minutes, BCD
SCcr_in  input  8  preset seconds, BCD
HCout  output  8  current hours, BCD
MCout  output  8  current minutes, BCD
SCout  output  8  current seconds, BCD
running  output  1  high in RUN state
done_pulse  output  1  one-clk pulse on the expiry edge
alarm  output  1  alarm indication

Behaviour:
- Reset (reset=0, asynchronous): HCout/MCout/SCout=8'h00, state IDLE, running=0, done_pulse=0, alarm=0, alarm tick counter=0.
- States: IDLE, PAUSED, RUN, DONE. running = (state==RUN).
- Load clamp, applied per digit at capture:
  - Hours: tens >2 -> 2; a value above 23 -> 23.
  - Minutes and seconds: tens >5 -> 5.
  - Any units digit >9 -> 9.
- load is accepted in IDLE, PAUSED and DONE. Outputs take the clamped preset on the same clk edge.
  - Next state is PAUSED if the clamped value is nonzero, else IDLE.
  - A load in DONE also clears alarm and the alarm counter.
- load in RUN: ignored.
- start:
  - PAUSED -> RUN.
  - Ignored in IDLE, RUN and DONE.
- stop:
  - RUN -> PAUSED.
  - Ignored elsewhere.
- Priority in one cycle: load > stop > start > tick.
  - stop together with tick in RUN: pause, no decrement.
  - start together with tick in PAUSED: enter RUN, no decrement on that edge.
- Decrement, in RUN only: on the edge where tick_1hz=1, count down one second with BCD borrow.
  - SC units 0 -> 9 with borrow; SC tens 0 -> 5 with borrow.
  - MC borrows the same way into hours.
  - HC units 0 -> 9 with borrow into HC tens.
  - Registers never hold a non-BCD value.
- Expiry: if the decrement produces 00:00:00, that same edge does the following:
  - state -> DONE;
  - done_pulse=1 for exactly one clk;
  - alarm=1;
  - alarm counter is loaded with ALARM_SECS.
- DONE:
  - Each tick decrements the alarm counter. When it reaches 0, alarm=0 and state -> IDLE on that edge.
  - alarm_clr: alarm=0 and state -> IDLE on the next edge.
  - start and stop are ignored.
- Outputs are registered. Latency from a tick or load edge to the new value is 1 clk.
- 00:00:01 plus one tick reaches DONE. 23:59:59 is the maximum count.

Optional Feature:
CRONO_BLINK_EN:
- Defined: while in DONE, alarm starts at 1 on the expiry edge and toggles on every tick_1hz. It is forced to 0 on leaving DONE.
- Not defined: alarm is held steady at 1 for the whole DONE period.
- Timing of the DONE exit is the same in both builds.

Test Plan:
- Preset 00:01:00, load, start, one tick -> outputs 00:00:59; running=1.
- Preset 10:00:00, load, start, one tick -> 09:59:59. Preset 20:00:00 plus one tick -> 19:59:59.
- Preset 00:00:02, load, start, two ticks -> 00:00:00, done_pulse high for 1 clk, alarm=1. After 10 more ticks: alarm=0, state IDLE.
- In RUN at 00:00:30, assert stop and tick in the same cycle -> 00:00:30 held, running=0. Then start, one tick -> 00:00:29.
- Load HCcr_in=8'h39, MCcr_in=8'h7A, SCcr_in=8'hFF -> outputs 23:59:59. Load 8'h00/8'h00/8'h00 -> stays IDLE; start is ignored.
- Drive reset=0 mid-RUN, asynchronously between clk edges -> all outputs 0 immediately. alarm_clr during DONE -> alarm=0 on the next edge.
